// File: rtl/mmm_pkg.sv
// Shared types and width helpers for the matrix-multiply datapath blocks.
package mmm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } drain_state_t;

  localparam int unsigned DefaultN         = 4;
  localparam int unsigned DefaultDataWidth = 16;

  // Index width for a count of n, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drain_counter.sv
// Nested row/column counter over an N x N block; saturates at (N-1, N-1).
module drain_counter
  import mmm_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  advance,
  output logic [idx_w(N)-1:0]   row,
  output logic [idx_w(N)-1:0]   col,
  output logic                  at_last
);

  localparam int unsigned W = idx_w(N);
  localparam logic [W-1:0] Max = W'(N - 1);

  logic [W-1:0] row_q;
  logic [W-1:0] col_q;

  assign row     = row_q;
  assign col     = col_q;
  assign at_last = (row_q == Max) && (col_q == Max);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (advance && !at_last) begin
      if (col_q == Max) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_drain.sv
// Snapshots an N x N result block on start and streams it out row-major over valid/ready.
module result_drain
  import mmm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned N          = DefaultN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [N*N*DATA_WIDTH-1:0]    result_in,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [idx_w(N)-1:0]          out_row,
  output logic [idx_w(N)-1:0]          out_col,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned RW = idx_w(N);
  localparam int unsigned IW = idx_w(N * N);

  drain_state_t          state_q;
  logic [DATA_WIDTH-1:0] buf_q [N*N];
  logic [RW-1:0]         row;
  logic [RW-1:0]         col;
  logic                  at_last;
  logic [IW-1:0]         idx;
  logic                  stream;
  logic                  launch;

  assign stream = (state_q == STREAM);
  assign launch = (state_q == IDLE) && start;
  assign idx    = IW'(row) * IW'(N) + IW'(col);

  drain_counter #(
    .N (N)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (launch),
    .advance (stream && out_ready),
    .row     (row),
    .col     (col),
    .at_last (at_last)
  );

  // Buffer has no reset: its contents only matter after a snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N * N; i++) begin
              buf_q[i] <= result_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
            state_q <= STREAM;
          end
        end
        STREAM:  if (out_ready && at_last) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state; gated to zero outside STREAM.
  assign out_valid = stream;
  assign out_data  = stream ? buf_q[idx] : '0;
  assign out_row   = stream ? row : '0;
  assign out_col   = stream ? col : '0;
  assign out_last  = stream && at_last;
  assign busy      = stream;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: N=2/DW=16 instance plus an N=4/DW=32 instance.
module tb_result_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start2, ready2;
  logic [63:0] res2;
  logic        valid2, last2, busy2, done2;
  logic [15:0] data2;
  logic [0:0]  row2, col2;

  logic         start4, ready4;
  logic [511:0] res4;
  logic         valid4, last4, busy4, done4;
  logic [31:0]  data4;
  logic [1:0]   row4, col4;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] Res2Init = {16'h0044, 16'h0033, 16'h0022, 16'h0011};

  result_drain #(.DATA_WIDTH(16), .N(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .start     (start2),
    .result_in (res2),
    .out_ready (ready2),
    .out_valid (valid2),
    .out_data  (data2),
    .out_row   (row2),
    .out_col   (col2),
    .out_last  (last2),
    .busy      (busy2),
    .done      (done2)
  );

  result_drain #(.DATA_WIDTH(32), .N(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start4),
    .result_in (res4),
    .out_ready (ready4),
    .out_valid (valid4),
    .out_data  (data4),
    .out_row   (row4),
    .out_col   (col4),
    .out_last  (last4),
    .busy      (busy4),
    .done      (done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks the full N=2 output bundle for one cycle.
  task automatic expect2(input string tag, input logic v, input logic [15:0] d, input logic r,
                         input logic c, input logic l, input logic dn);
    check({tag, ".valid"}, 32'(valid2), 32'(v));
    check({tag, ".busy"},  32'(busy2),  32'(v));
    check({tag, ".data"},  32'(data2),  32'(d));
    check({tag, ".row"},   32'(row2),   32'(r));
    check({tag, ".col"},   32'(col2),   32'(c));
    check({tag, ".last"},  32'(last2),  32'(l));
    check({tag, ".done"},  32'(done2),  32'(dn));
  endtask

  task automatic drain_rest2(input string tag);
    expect2({tag, ".e2"}, 1'b1, 16'h0033, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect2({tag, ".e3"}, 1'b1, 16'h0044, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    expect2({tag, ".done"}, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expect2({tag, ".idle"}, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    start2 = 1'b0;
    ready2 = 1'b1;
    res2   = Res2Init;
    start4 = 1'b0;
    ready4 = 1'b1;
    for (int i = 0; i < 16; i++) res4[i*32 +: 32] = 32'(i);
    @(negedge clk);
    tick();
    expect2("rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst4.valid", 32'(valid4), 32'd0);
    check("rst4.done",  32'(done4),  32'd0);
    reset = 1'b0;
    tick();

    // Basic drain
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    expect2("basic.e0", 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect2("basic.e1", 1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drain_rest2("basic");

    // Backpressure on the second element
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    expect2("bp.e0", 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    ready2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect2("bp.hold", 1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    expect2("bp.held", 1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0);
    ready2 = 1'b1;
    tick();
    drain_rest2("bp");

    // Snapshot isolation
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    res2   = {64{1'b1}};
    expect2("snap.e0", 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect2("snap.e1", 1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drain_rest2("snap");
    res2 = Res2Init;

    // Start ignored during STREAM and DONE
    start2 = 1'b1;
    tick();
    expect2("ign.e0", 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    start2 = 1'b0;
    expect2("ign.e1", 1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect2("ign.e2", 1'b1, 16'h0033, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect2("ign.e3", 1'b1, 16'h0044, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    start2 = 1'b1;
    expect2("ign.done", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    start2 = 1'b0;
    expect2("ign.idle", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect2("ign.idle2", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream, then restart from the first element
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    expect2("rms.e0", 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect2("rms.e1", 1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect2("rms.rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect2("rms.idle", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    expect2("rms.re0", 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect2("rms.re1", 1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drain_rest2("rms");

    // N=4, DATA_WIDTH=32 sweep: element value equals its index
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("p4.valid", 32'(valid4), 32'd1);
      check("p4.data",  data4,       32'(k));
      check("p4.row",   32'(row4),   32'(k / 4));
      check("p4.col",   32'(col4),   32'(k % 4));
      check("p4.last",  32'(last4),  32'(k == 15));
      check("p4.done",  32'(done4),  32'd0);
      tick();
    end
    check("p4.end.valid", 32'(valid4), 32'd0);
    check("p4.end.done",  32'(done4),  32'd1);
    tick();
    check("p4.idle.done", 32'(done4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
